// File: rtl/sm3_pad_blk_asm.sv
// SM3 padded-stream sink: packs 32/64-bit beats into 512-bit blocks across two
// banks and hands each full block, tagged first/last, to the compression core.
module sm3_pad_blk_asm #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pad_d_i,
  input  logic          pad_vld_i,
  input  logic          pad_lst_i,
  output logic          pad_ena_o,
  output logic [511:0]  blk_d_o,
  output logic          blk_vld_o,
  input  logic          blk_rdy_i,
  output logic          blk_first_o,
  output logic          blk_lst_o,
  output logic          err_ovf_o,
  output logic          err_fmt_o,
  input  logic          err_clr_i
);

  localparam int WPB = DW / 32;
  localparam int BPB = 16 / WPB;
  localparam logic [3:0] LAST_BEAT = 4'(BPB - 1);

  logic [511:0] bank_data [2];
  logic [1:0]   bank_first;
  logic [1:0]   bank_lst;
  logic [1:0]   bank_full;
  logic [1:0]   full_nxt;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [3:0]   wr_cnt;
  logic         msg_start;
  logic         err_ovf;
  logic         err_fmt;

  logic beat_acc;
  logic beat_ovf;
  logic beat_last;
  logic beat_fmt;
  logic pop;

  // Overflow is judged on the pre-pop state of the write bank.
  assign beat_acc  = pad_vld_i & ~bank_full[wr_ptr];
  assign beat_ovf  = pad_vld_i &  bank_full[wr_ptr];
  assign beat_last = beat_acc & (wr_cnt == LAST_BEAT);
  assign beat_fmt  = beat_acc & pad_lst_i & (wr_cnt != LAST_BEAT);
  assign pop       = bank_full[rd_ptr] & blk_rdy_i;

  // Completion and pop can never target the same bank: a completing bank is
  // empty by definition, a popped bank is full.
  always_comb begin
    full_nxt = bank_full;
    if (pop)       full_nxt[rd_ptr] = 1'b0;
    if (beat_last) full_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) bank_data[b] <= '0;
    end else if (beat_acc) begin
      bank_data[wr_ptr][511 - int'(wr_cnt) * DW -: DW] <= pad_d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_first <= 2'b00;
      bank_lst   <= 2'b00;
      bank_full  <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_cnt     <= 4'd0;
      msg_start  <= 1'b1;
    end else begin
      bank_full <= full_nxt;
      if (pop) rd_ptr <= ~rd_ptr;
      if (beat_acc) begin
        if (beat_last) begin
          bank_first[wr_ptr] <= msg_start;
          bank_lst[wr_ptr]   <= pad_lst_i;
          wr_ptr             <= ~wr_ptr;
          wr_cnt             <= 4'd0;
          msg_start          <= pad_lst_i;
        end else if (pad_lst_i) begin
          // Short message: drop the partial block and resync on the next one.
          wr_cnt    <= 4'd0;
          msg_start <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_fmt <= 1'b0;
    end else if (err_clr_i) begin
      err_ovf <= 1'b0;
      err_fmt <= 1'b0;
    end else begin
      if (beat_ovf) err_ovf <= 1'b1;
      if (beat_fmt) err_fmt <= 1'b1;
    end
  end

  assign pad_ena_o   = ~bank_full[wr_ptr];
  assign blk_vld_o   = bank_full[rd_ptr];
  assign blk_d_o     = blk_vld_o ? bank_data[rd_ptr] : 512'd0;
  assign blk_first_o = blk_vld_o & bank_first[rd_ptr];
  assign blk_lst_o   = blk_vld_o & bank_lst[rd_ptr];
  assign err_ovf_o   = err_ovf;
  assign err_fmt_o   = err_fmt;

endmodule

// File: tb/tb_sm3_pad_blk_asm.sv
// Scoreboard bench for sm3_pad_blk_asm: DW=32 and DW=64 instances, expected
// blocks queued at stimulus time and checked by per-instance monitors.
module tb_sm3_pad_blk_asm;

  typedef struct packed {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]  pad_d32;
  logic         pad_vld32, pad_lst32, pad_ena32, rdy32, clr32;
  logic [511:0] d32;
  logic         vld32, first32, lst32, ovf32, fmt32;

  logic [63:0]  pad_d64;
  logic         pad_vld64, pad_lst64, pad_ena64, rdy64, clr64;
  logic [511:0] d64;
  logic         vld64, first64, lst64, ovf64, fmt64;

  sm3_pad_blk_asm #(.DW(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .pad_d_i(pad_d32), .pad_vld_i(pad_vld32),
    .pad_lst_i(pad_lst32), .pad_ena_o(pad_ena32), .blk_d_o(d32), .blk_vld_o(vld32),
    .blk_rdy_i(rdy32), .blk_first_o(first32), .blk_lst_o(lst32),
    .err_ovf_o(ovf32), .err_fmt_o(fmt32), .err_clr_i(clr32)
  );

  sm3_pad_blk_asm #(.DW(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .pad_d_i(pad_d64), .pad_vld_i(pad_vld64),
    .pad_lst_i(pad_lst64), .pad_ena_o(pad_ena64), .blk_d_o(d64), .blk_vld_o(vld64),
    .blk_rdy_i(rdy64), .blk_first_o(first64), .blk_lst_o(lst64),
    .err_ovf_o(ovf64), .err_fmt_o(fmt64), .err_clr_i(clr64)
  );

  int total = 0;
  int bad = 0;
  blk_t q32[$];
  blk_t q64[$];

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Block whose 16 words are base, base+1, ... with W0 in the top slot.
  function automatic logic [511:0] mkBlock(input logic [31:0] base);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic blk_t mkExp(input logic [31:0] base, input logic f, input logic l);
    blk_t e;
    e.d = mkBlock(base);
    e.f = f;
    e.l = l;
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] d, input logic lst);
    pad_vld32 = 1'b1; pad_d32 = d; pad_lst32 = lst;
    @(posedge clk); #1;
    pad_vld32 = 1'b0; pad_d32 = '0; pad_lst32 = 1'b0;
  endtask

  task automatic applyStimulus64(input logic [63:0] d, input logic lst);
    pad_vld64 = 1'b1; pad_d64 = d; pad_lst64 = lst;
    @(posedge clk); #1;
    pad_vld64 = 1'b0; pad_d64 = '0; pad_lst64 = 1'b0;
  endtask

  task automatic sendBeats32(input logic [31:0] base, input int n, input logic lstLast, input logic chkEna);
    for (int i = 0; i < n; i++) begin
      if (chkEna) checkOutput("dw32_pad_ena_stream", 512'(pad_ena32), 512'd1);
      applyStimulus(base + 32'(i), lstLast && (i == n - 1));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon32
    blk_t e;
    if (rst_n && vld32 && rdy32) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL dw32_unexpected_block actual=%0h required=none", d32);
      end else begin
        e = q32.pop_front();
        checkOutput("dw32_blk_data", d32, e.d);
        checkOutput("dw32_blk_first", 512'(first32), 512'(e.f));
        checkOutput("dw32_blk_lst", 512'(lst32), 512'(e.l));
      end
    end
  end

  always @(negedge clk) begin : mon64
    blk_t e;
    if (rst_n && vld64 && rdy64) begin
      if (q64.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL dw64_unexpected_block actual=%0h required=none", d64);
      end else begin
        e = q64.pop_front();
        checkOutput("dw64_blk_data", d64, e.d);
        checkOutput("dw64_blk_first", 512'(first64), 512'(e.f));
        checkOutput("dw64_blk_lst", 512'(lst64), 512'(e.l));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    pad_d32 = '0; pad_vld32 = 0; pad_lst32 = 0; rdy32 = 0; clr32 = 0;
    pad_d64 = '0; pad_vld64 = 0; pad_lst64 = 0; rdy64 = 0; clr64 = 0;
    #3;
    checkOutput("rst_blk_vld", 512'(vld32), 512'd0);
    checkOutput("rst_pad_ena", 512'(pad_ena32), 512'd1);
    checkOutput("rst_blk_d", d32, 512'd0);
    checkOutput("rst_first_lst", 512'({first32, lst32}), 512'd0);
    checkOutput("rst_errors", 512'({ovf32, fmt32}), 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);

    // Single-block message; valid one cycle after the last beat, for one cycle.
    rdy32 = 1'b1;
    q32.push_back(mkExp(32'h0, 1'b1, 1'b1));
    sendBeats32(32'h0, 16, 1'b1, 1'b0);
    checkOutput("t1_vld_after_last", 512'(vld32), 512'd1);
    checkOutput("t1_w0", 512'(d32[511:480]), 512'd0);
    checkOutput("t1_w15", 512'(d32[31:0]), 512'h0F);
    cycles(1);
    checkOutput("t1_vld_one_cycle", 512'(vld32), 512'd0);

    // Both banks full, then an overflow beat that must be dropped.
    rdy32 = 1'b0;
    q32.push_back(mkExp(32'h100, 1'b1, 1'b0));
    q32.push_back(mkExp(32'h110, 1'b0, 1'b1));
    sendBeats32(32'h100, 16, 1'b0, 1'b0);
    checkOutput("ovf_ena_one_full", 512'(pad_ena32), 512'd1);
    sendBeats32(32'h110, 16, 1'b1, 1'b0);
    checkOutput("ovf_ena_low", 512'(pad_ena32), 512'd0);
    applyStimulus(32'hDEAD_BEEF, 1'b0);
    checkOutput("ovf_flag", 512'(ovf32), 512'd1);
    cycles(2);
    checkOutput("ovf_data_held", d32, mkBlock(32'h100));
    checkOutput("ovf_first_held", 512'(first32), 512'd1);
    checkOutput("ovf_ena_still_low", 512'(pad_ena32), 512'd0);
    rdy32 = 1'b1;
    cycles(3);
    clr32 = 1'b1; cycles(1); clr32 = 1'b0;
    checkOutput("ovf_cleared", 512'(ovf32), 512'd0);

    // Short message: lst on beat 5 is a framing error, nothing emitted.
    sendBeats32(32'h300, 5, 1'b1, 1'b0);
    checkOutput("fmt_flag", 512'(fmt32), 512'd1);
    checkOutput("fmt_no_vld", 512'(vld32), 512'd0);
    cycles(2);
    checkOutput("fmt_still_no_vld", 512'(vld32), 512'd0);
    q32.push_back(mkExp(32'h400, 1'b1, 1'b1));
    sendBeats32(32'h400, 16, 1'b1, 1'b0);
    cycles(2);
    checkOutput("fmt_sticky", 512'(fmt32), 512'd1);
    clr32 = 1'b1; cycles(1); clr32 = 1'b0;
    checkOutput("fmt_cleared", 512'(fmt32), 512'd0);

    // Pop of the older bank in the same cycle the other bank completes.
    rdy32 = 1'b0;
    q32.push_back(mkExp(32'h600, 1'b1, 1'b0));
    q32.push_back(mkExp(32'h610, 1'b0, 1'b1));
    sendBeats32(32'h600, 16, 1'b0, 1'b0);
    sendBeats32(32'h610, 15, 1'b0, 1'b0);
    rdy32 = 1'b1;
    applyStimulus(32'h61F, 1'b1);
    checkOutput("coinc_pad_ena", 512'(pad_ena32), 512'd1);
    checkOutput("coinc_vld", 512'(vld32), 512'd1);
    cycles(2);

    // Continuous 4-block message with ready toggling every cycle.
    rdy32 = 1'b0;
    q32.push_back(mkExp(32'hA00, 1'b1, 1'b0));
    q32.push_back(mkExp(32'hA10, 1'b0, 1'b0));
    q32.push_back(mkExp(32'hA20, 1'b0, 1'b0));
    q32.push_back(mkExp(32'hA30, 1'b0, 1'b1));
    fork
      begin
        for (int i = 0; i < 70; i++) begin
          @(posedge clk); #1;
          rdy32 = ~rdy32;
        end
      end
      sendBeats32(32'hA00, 64, 1'b1, 1'b1);
    join
    checkOutput("toggle_no_ovf", 512'(ovf32), 512'd0);
    rdy32 = 1'b1;
    cycles(3);

    // Reset mid-block with one bank full discards everything.
    rdy32 = 1'b0;
    sendBeats32(32'hB00, 16, 1'b0, 1'b0);
    sendBeats32(32'hB10, 7, 1'b0, 1'b0);
    checkOutput("prerst_vld", 512'(vld32), 512'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_vld", 512'(vld32), 512'd0);
    checkOutput("midrst_blk_d", d32, 512'd0);
    checkOutput("midrst_pad_ena", 512'(pad_ena32), 512'd1);
    checkOutput("midrst_first_lst", 512'({first32, lst32}), 512'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rdy32 = 1'b1;
    q32.push_back(mkExp(32'hC00, 1'b1, 1'b1));
    sendBeats32(32'hC00, 16, 1'b1, 1'b0);
    cycles(3);

    // DW=64: three-block message then a single-block message.
    rdy64 = 1'b1;
    q64.push_back(mkExp(32'h9000_0000, 1'b1, 1'b0));
    q64.push_back(mkExp(32'h9000_0010, 1'b0, 1'b0));
    q64.push_back(mkExp(32'h9000_0020, 1'b0, 1'b1));
    for (int j = 0; j < 24; j++)
      applyStimulus64({32'h9000_0000 + 32'(2*j), 32'h9000_0000 + 32'(2*j + 1)}, j == 23);
    q64.push_back(mkExp(32'h9000_0030, 1'b1, 1'b1));
    for (int j = 0; j < 8; j++)
      applyStimulus64({32'h9000_0030 + 32'(2*j), 32'h9000_0030 + 32'(2*j + 1)}, j == 7);
    cycles(4);
    checkOutput("dw64_no_errors", 512'({ovf64, fmt64}), 512'd0);

    checkOutput("dw32_queue_drained", 512'(q32.size()), 512'd0);
    checkOutput("dw64_queue_drained", 512'(q64.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
